// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// lane masks and the captured-request payload.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [DATA_W-1:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [DATA_W-1:0] HALF_MASK = 32'h0000_ffff;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic              write;
    size_e             size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave is the unit's view; master is the pipeline/memory environment's view.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: load extraction/extension, store lane merge and
// misalignment detection. Misaligned halves/words are steered force-aligned.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        i_offset,
  input  size_e             i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_store_word,
  output logic              o_misalign
);

  logic [4:0]        w_shift;
  logic [DATA_W-1:0] w_lane;

  // Offset 0 is the most significant lane, so the shift grows as the offset shrinks
  always_comb begin
    w_shift      = 5'd0;
    w_lane       = '0;
    o_load_data  = i_word;
    o_store_word = i_wdata;
    o_misalign   = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_shift      = {~i_offset, 3'b000};
        w_lane       = i_word >> w_shift;
        o_load_data  = {{(DATA_W-BYTE_W){i_signed & w_lane[BYTE_W-1]}}, w_lane[BYTE_W-1:0]};
        o_store_word = (i_word & ~(BYTE_MASK << w_shift)) | ((i_wdata & BYTE_MASK) << w_shift);
      end
      SZ_HALF: begin
        o_misalign   = i_offset[0];
        w_shift      = {~i_offset[1], 4'b0000};
        w_lane       = i_word >> w_shift;
        o_load_data  = {{(DATA_W-HALF_W){i_signed & w_lane[HALF_W-1]}}, w_lane[HALF_W-1:0]};
        o_store_word = (i_word & ~(HALF_MASK << w_shift)) | ((i_wdata & HALF_MASK) << w_shift);
      end
      SZ_WORD: begin
        o_misalign = |i_offset;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request at a time, sub-word stores via
// read-modify-write, registered memory strobes and response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  req_t              r_req;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_misalign;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_capture;
  logic              w_req_ready_n;
  logic              w_resp_valid_n;
  logic [DATA_W-1:0] w_resp_rdata_n;
  logic              w_resp_misalign_n;
  logic              w_mem_read_n;
  logic              w_mem_write_n;
  logic [DATA_W-1:0] w_mem_wdata_n;
  logic              w_trap;

  logic [1:0]        w_la_off;
  size_e             w_la_size;
  logic [DATA_W-1:0] w_la_load;
  logic [DATA_W-1:0] w_la_store;
  logic              w_la_misalign;

  // In IDLE the steering unit looks at the live request (for the trap decision),
  // afterwards at the captured one
  assign w_la_off  = (r_state == ST_IDLE) ? bus.req_addr[1:0] : r_addr[1:0];
  assign w_la_size = (r_state == ST_IDLE) ? size_e'(bus.req_size) : r_req.size;

  lsu_lane_align u_lane_align (
    .i_offset     (w_la_off),
    .i_size       (w_la_size),
    .i_signed     (r_req.sgn),
    .i_word       (bus.mem_rdata),
    .i_wdata      (r_req.wdata),
    .o_load_data  (w_la_load),
    .o_store_word (w_la_store),
    .o_misalign   (w_la_misalign)
  );

  // Illegal size traps even when misaligned accesses would otherwise be force-aligned
  assign w_trap = w_la_misalign && (MISALIGN_TRAP || (w_la_size == SZ_ILL));

  always_comb begin
    w_next            = r_state;
    w_capture         = 1'b0;
    w_req_ready_n     = 1'b0;
    w_resp_valid_n    = 1'b0;
    w_resp_rdata_n    = '0;
    w_resp_misalign_n = 1'b0;
    w_mem_read_n      = 1'b0;
    w_mem_write_n     = 1'b0;
    w_mem_wdata_n     = '0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready_n = 1'b1;
        if (bus.req_valid) begin
          w_capture     = 1'b1;
          w_req_ready_n = 1'b0;
          if (w_trap) begin
            w_next            = ST_RESP;
            w_resp_valid_n    = 1'b1;
            w_resp_misalign_n = 1'b1;
          end else begin
            w_next = ST_ISSUE;
            if (bus.req_write && (size_e'(bus.req_size) == SZ_WORD)) begin
              w_mem_write_n = 1'b1;
              w_mem_wdata_n = bus.req_wdata;
            end else begin
              w_mem_read_n = 1'b1;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (r_req.write && (r_req.size == SZ_WORD)) begin
          w_next         = ST_RESP;
          w_resp_valid_n = 1'b1;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_req.write) begin
          w_next        = ST_WRITE;
          w_mem_write_n = 1'b1;
          w_mem_wdata_n = w_la_store;
        end else begin
          w_next         = ST_RESP;
          w_resp_valid_n = 1'b1;
          w_resp_rdata_n = w_la_load;
        end
      end
      ST_WRITE: begin
        w_next         = ST_RESP;
        w_resp_valid_n = 1'b1;
      end
      ST_RESP: begin
        w_next        = ST_IDLE;
        w_req_ready_n = 1'b1;
      end
      default: begin
        w_next        = ST_IDLE;
        w_req_ready_n = 1'b1;
      end
    endcase
  end

  // Strobes are flops, so an async reset kills a pending write in the same instant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_req           <= '0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_misalign <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_wdata     <= '0;
    end else begin
      r_state         <= w_next;
      r_req_ready     <= w_req_ready_n;
      r_resp_valid    <= w_resp_valid_n;
      r_resp_rdata    <= w_resp_rdata_n;
      r_resp_misalign <= w_resp_misalign_n;
      r_mem_read      <= w_mem_read_n;
      r_mem_write     <= w_mem_write_n;
      r_mem_wdata     <= w_mem_wdata_n;
      if (w_capture) begin
        r_addr <= bus.req_addr;
        r_req  <= '{write: bus.req_write, size: size_e'(bus.req_size),
                    sgn: bus.req_signed, wdata: bus.req_wdata};
      end
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_misalign = r_resp_misalign;
  assign bus.mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;

endmodule
